sb_regfile: RTL
===============

# sb_regfile

Parametrised, clocked general-register file for the decode stage, with combinational read ports, one writeback port, same-cycle write-to-read bypass and a per-register busy scoreboard. Decode marks a destination busy when an instruction issues, and writeback clears that mark. This lets decode detect RAW and WAW hazards without comparing against every pipeline stage.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 16, number of registers (power of two); AW = log2(DEPTH)
- NREAD, 2, number of read ports
- ZERO_REG, 0, 1 = register 0 is hardwired to zero (reads 0, writes ignored, never busy)
- BYPASS, 1, 1 = a writeback is forwarded to reads of the same address in the same cycle

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- rd_addr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW]
- rd_data  out  NREAD*DATA_W  read data for each port
- rd_busy  out  NREAD  1 = the addressed register has a pending write
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register
- wr_data  in  DATA_W  writeback value
- iss_en  in  1  request to mark iss_addr busy (instruction issue)
- iss_addr  in  AW  destination being issued
- iss_stall  out  1  1 = the issue is refused this cycle (WAW hazard)
- flush  in  1  clear all busy bits (pipeline squash)
- busy_cnt  out  AW+1  number of busy registers

## Operation
- Storage: array regs[DEPTH] of DATA_W bits and a vector busy[DEPTH].
- Reset (rst=0, asynchronous): all regs = 0 and all busy = 0. Outputs while in reset: rd_data = 0, rd_busy = 0, iss_stall = 0, busy_cnt = 0.
- Read (combinational, per port i):
  - rd_data = wr_data if BYPASS && wr_en && wr_addr==rd_addr[i] && the address is not the zero register; otherwise rd_data = regs[rd_addr[i]].
  - With ZERO_REG=1, address 0 always reads 0.
- rd_busy[i] = busy[a] && !(wr_en && wr_addr==a), where a = rd_addr[i]. The clear from a same-cycle writeback is visible immediately. When BYPASS=0, rd_busy[i] = busy[a].
- Write: on the clock edge with wr_en=1, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0. With ZERO_REG=1, address 0 is ignored.
- Issue:
  - iss_stall = iss_en && busy[iss_addr] && !(wr_en && wr_addr==iss_addr).
  - If iss_en && !iss_stall, busy[iss_addr] <= 1 on the edge. With ZERO_REG=1, address 0 is ignored and never stalls.
  - The issuer must hold iss_en/iss_addr until iss_stall=0.
- Simultaneous writeback and issue to the same address: the write completes, the issue succeeds, and busy ends at 1 (the set wins over the clear).
- flush:
  - Clears all busy bits on the edge and overrides any set from an issue in the same cycle.
  - A writeback in the same cycle still updates regs.
  - iss_stall is forced to 0 while flush=1.
- busy_cnt: population count of the registered busy vector. It reflects the state after the last edge, not same-cycle requests.
- Write to a register that is not busy is legal; the data is updated and busy stays 0.

## Timing
- Read latency: 0 cycles (combinational).
- A write is visible through the array from the cycle after the edge, and through the bypass in the same cycle.
- Issue becomes visible on rd_busy and busy_cnt in the cycle after the accepted edge.
- Reset mid-operation: state clears immediately on rst falling (no clock needed) and stays cleared until the first rising edge after rst returns to 1.
- Single clock domain; no multicycle paths.

## Test plan
- Reset / basic write: assert rst=0 mid-run, then release. All ports read 0 and busy_cnt=0. Write 32'hDEADBEEF to r5; the next cycle, rd_addr port0=5 gives 32'hDEADBEEF.
- Bypass: wr_en=1, wr_addr=3, wr_data=32'h12345678, with rd_addr port1=3 in the same cycle. rd_data port1=32'h12345678 in that cycle. With BYPASS=0, the old value (0) is returned.
- Scoreboard RAW:
  - Issue r7; the next cycle rd_busy=1 for r7 and busy_cnt=1.
  - Write back r7 with 32'hA5; in that cycle rd_busy=0 and rd_data=32'hA5.
  - The cycle after, busy_cnt=0.
- WAW stall:
  - With r2 busy, iss_en for r2 gives iss_stall=1 and busy_cnt stays 1.
  - Add a same-cycle writeback to r2: iss_stall=0, and after the edge busy[r2]=1 and busy_cnt=1.
- Flush: issue r1, r4 and r9 (busy_cnt=3), then flush=1 together with iss_en for r10. After the edge busy_cnt=0 and r10 is not busy.
- ZERO_REG=1: write 32'hFFFFFFFF to r0 and issue r0. r0 reads 0, iss_stall=0, rd_busy=0 and busy_cnt=0.

Source files
------------

// File: rtl/sb_regfile.sv
// Decode-stage register file with combinational reads, one writeback port,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module sb_regfile #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  output logic                    iss_stall,
  input  logic                    flush,
  output logic [AW:0]             busy_cnt
);

  function automatic logic [AW:0] f_popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      c = c + {{AW{1'b0}}, v[k]};
    end
    return c;
  endfunction

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [AW:0]       r_busy_cnt;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wr_ok;
  logic              w_iss_zero;
  logic              w_iss_ok;

  assign w_wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign w_iss_zero = (ZERO_REG != 0) && (iss_addr == '0);

  // A same-cycle writeback to the issue target releases the hazard.
  assign iss_stall = rst && iss_en && !flush && !w_iss_zero && r_busy[iss_addr]
                     && !(wr_en && (wr_addr == iss_addr));
  assign w_iss_ok  = iss_en && !iss_stall && !w_iss_zero;
  assign busy_cnt  = r_busy_cnt;

  generate
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0] w_a;
      logic          w_zero;
      logic          w_hit;
      assign w_a    = rd_addr[g*AW +: AW];
      assign w_zero = (ZERO_REG != 0) && (w_a == '0);
      assign w_hit  = (BYPASS != 0) && wr_en && (wr_addr == w_a);
      assign rd_data[g*DATA_W +: DATA_W] = (!rst || w_zero) ? '0 :
                                           w_hit ? wr_data : r_regs[w_a];
      assign rd_busy[g] = rst && !w_zero && r_busy[w_a] && !w_hit;
    end
  endgenerate

  // Next busy vector: writeback clears, issue sets over it, flush clears everything.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
    if (w_iss_ok) begin
      w_busy_nxt[iss_addr] = 1'b1;
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
    if (flush) begin
      w_busy_nxt = '0;
    end else begin
      w_busy_nxt = w_busy_nxt;
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= f_popcount(w_busy_nxt);
    end
  end

  // Register array writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

endmodule
